// File: rtl/piezo_sound_ctrl.sv
// Piezo buzzer sound sequencer: fire rise plays one tone.
// Hit rise plays two descending notes with a silent gap between them.
module piezo_sound_ctrl #(
  parameter int CNT_W     = 24,
  parameter int FIRE_HALF = 12000,
  parameter int HIT1_HALF = 9556,
  parameter int HIT2_HALF = 19112,
  parameter int NOTE_LEN  = 5000000,
  parameter int GAP_LEN   = 1250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire,
  input  logic       hit,
  input  logic       en,
  output logic       piezo,
  output logic       busy,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FIRE = 3'd1,
    ST_HIT1 = 3'd2,
    ST_GAP  = 3'd3,
    ST_HIT2 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] FIRE_LAST = CNT_W'(FIRE_HALF - 1);
  localparam logic [CNT_W-1:0] HIT1_LAST = CNT_W'(HIT1_HALF - 1);
  localparam logic [CNT_W-1:0] HIT2_LAST = CNT_W'(HIT2_HALF - 1);
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] dur_cnt_r;
  logic [CNT_W-1:0] half_cnt_r;
  logic             tone_r;
  logic             fire_d_r;
  logic             hit_d_r;
  logic             piezo_r;
  logic             busy_r;
  logic             fire_rise_s;
  logic             hit_rise_s;
  logic             entry_s;
  logic             expire_s;
  logic             tone_state_s;
  logic [CNT_W-1:0] dur_last_s;
  logic [CNT_W-1:0] half_last_s;

  assign fire_rise_s = fire & ~fire_d_r;
  assign hit_rise_s  = hit & ~hit_d_r;
  assign expire_s    = (state_r != ST_IDLE) && (dur_cnt_r == dur_last_s);

  // Per-state duration and half-period limits
  always_comb begin
    dur_last_s   = {CNT_W{1'b0}};
    half_last_s  = {CNT_W{1'b0}};
    tone_state_s = 1'b0;
    case (state_r)
      ST_FIRE: begin
        dur_last_s   = NOTE_LAST;
        half_last_s  = FIRE_LAST;
        tone_state_s = 1'b1;
      end
      ST_HIT1: begin
        dur_last_s   = NOTE_LAST;
        half_last_s  = HIT1_LAST;
        tone_state_s = 1'b1;
      end
      ST_GAP: begin
        dur_last_s   = GAP_LAST;
      end
      ST_HIT2: begin
        dur_last_s   = NOTE_LAST;
        half_last_s  = HIT2_LAST;
        tone_state_s = 1'b1;
      end
      default: begin
        dur_last_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Next-state selection; a rise always (re)enters its target state
  always_comb begin
    state_next_s = state_r;
    entry_s      = 1'b0;
    if (hit_rise_s) begin
      state_next_s = ST_HIT1;
      entry_s      = 1'b1;
    end else if (fire_rise_s && (state_r == ST_IDLE || state_r == ST_FIRE)) begin
      state_next_s = ST_FIRE;
      entry_s      = 1'b1;
    end else if (expire_s) begin
      entry_s = 1'b1;
      case (state_r)
        ST_HIT1: state_next_s = ST_GAP;
        ST_GAP:  state_next_s = ST_HIT2;
        default: state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State, counters, tone and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      dur_cnt_r  <= {CNT_W{1'b0}};
      half_cnt_r <= {CNT_W{1'b0}};
      tone_r     <= 1'b0;
      fire_d_r   <= fire;
      hit_d_r    <= hit;
      piezo_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      fire_d_r <= fire;
      hit_d_r  <= hit;
      state_r  <= state_next_s;
      busy_r   <= (state_next_s != ST_IDLE);
      piezo_r  <= tone_r & en & tone_state_s;
      if (entry_s) begin
        dur_cnt_r  <= {CNT_W{1'b0}};
        half_cnt_r <= {CNT_W{1'b0}};
        tone_r     <= 1'b0;
      end else if (state_r != ST_IDLE) begin
        dur_cnt_r <= dur_cnt_r + CNT_W'(1);
        if (tone_state_s) begin
          if (half_cnt_r == half_last_s) begin
            half_cnt_r <= {CNT_W{1'b0}};
            tone_r     <= ~tone_r;
          end else begin
            half_cnt_r <= half_cnt_r + CNT_W'(1);
          end
        end
      end
    end
  end

  assign piezo   = piezo_r;
  assign busy    = busy_r;
  assign state_o = state_r;

endmodule

// File: tb/tb_piezo_sound_ctrl.sv
// Bench for piezo_sound_ctrl: vector table, directed sequences, and random
// stimulus against a cycle-level arithmetic model of the sound sequences.
module tb_piezo_sound_ctrl;

  logic       clk = 1'b0;
  logic       rst, fire, hit, en;
  logic       piezo, busy;
  logic [2:0] state_o;

  int n_pass = 0;
  int n_total = 0;

  piezo_sound_ctrl #(
    .CNT_W(8), .FIRE_HALF(3), .HIT1_HALF(2), .HIT2_HALF(4),
    .NOTE_LEN(20), .GAP_LEN(5)
  ) dut (
    .clk(clk), .rst(rst), .fire(fire), .hit(hit), .en(en),
    .piezo(piezo), .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle,1 fire,2 hit1,3 gap,4 hit2; t = cycles since entry
  int   m_phase = 0;
  int   m_t = 0;
  int   m_piezo = 0;
  logic m_fire_d = 1'b0;
  logic m_hit_d = 1'b0;

  function automatic int half_of(input int p);
    case (p)
      1: return 3;
      2: return 2;
      4: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int len_of(input int p);
    return (p == 3) ? 5 : 20;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_update();
    logic hr, fr;
    if (rst) begin
      m_phase = 0; m_t = 0; m_piezo = 0;
    end else begin
      hr = hit & ~m_hit_d;
      fr = fire & ~m_fire_d;
      m_piezo = (half_of(m_phase) != 0 && en && ((m_t / half_of(m_phase)) % 2 == 1)) ? 1 : 0;
      if (hr) begin
        m_phase = 2; m_t = 0;
      end else if (fr && (m_phase == 0 || m_phase == 1)) begin
        m_phase = 1; m_t = 0;
      end else if (m_phase != 0 && m_t == len_of(m_phase) - 1) begin
        m_phase = (m_phase == 2) ? 3 : (m_phase == 3) ? 4 : 0;
        m_t = 0;
      end else if (m_phase != 0) begin
        m_t++;
      end
    end
    m_fire_d = fire;
    m_hit_d  = hit;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("model_state", int'(state_o), m_phase);
    chk("model_busy", int'(busy), (m_phase != 0) ? 1 : 0);
    chk("model_piezo", int'(piezo), m_piezo);
  endtask

  task automatic do_reset();
    rst = 1'b1; fire = 1'b0; hit = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // Runs from a trigger until busy drops; optional fire low/high injections
  task automatic run_seq(input int lo_at, input int hi_at, output int nb,
                         output int n2, output int n3, output int n4,
                         output int first_hi, output int first_st, output int n_hi);
    bit done = 0;
    nb = 0; n2 = 0; n3 = 0; n4 = 0; first_hi = -1; first_st = -1; n_hi = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 0) first_st = int'(state_o);
      if (piezo && first_hi < 0) first_hi = i;
      if (piezo) n_hi++;
      if (!busy) begin
        done = 1;
        break;
      end
      nb++;
      if (state_o == 3'd2) n2++;
      if (state_o == 3'd3) n3++;
      if (state_o == 3'd4) n4++;
      if (i == lo_at) fire = 1'b0;
      if (i == hi_at) fire = 1'b1;
    end
    if (!done) chk("seq_timeout", 0, 1);
  endtask

  typedef struct {
    logic rst, fire, hit, en;
    int   st;
    logic bsy, pz;
  } vec_t;

  vec_t tbl[22];
  int nb, n2, n3, n4, fh, fs, nh;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fire = 1'b0; hit = 1'b0; en = 1'b1;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};

    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst; fire = tbl[i].fire; hit = tbl[i].hit; en = tbl[i].en;
      step();
      chk($sformatf("tbl%0d_state", i), int'(state_o), tbl[i].st);
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].bsy));
      chk($sformatf("tbl%0d_piezo", i), int'(piezo), int'(tbl[i].pz));
    end

    // fire held high through reset release is not a rise
    rst = 1'b1; fire = 1'b1; hit = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("held_fire_state", int'(state_o), 0);
      chk("held_fire_piezo", int'(piezo), 0);
    end

    do_reset();
    fire = 1'b1;
    run_seq(-1, -1, nb, n2, n3, n4, fh, fs, nh);
    chk("fire_busy_len", nb, 20);
    chk("fire_first_state", fs, 1);
    chk("fire_first_high", fh, 4);

    do_reset();
    hit = 1'b1;
    run_seq(-1, -1, nb, n2, n3, n4, fh, fs, nh);
    chk("hit_len", nb, 45);
    chk("hit1_len", n2, 20);
    chk("gap_len", n3, 5);
    chk("hit2_len", n4, 20);
    chk("hit_first_high", fh, 3);

    // fire aborted by hit 7 cycles later
    do_reset();
    fire = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("preempt_pre_state", int'(state_o), 1);
    hit = 1'b1;
    run_seq(-1, -1, nb, n2, n3, n4, fh, fs, nh);
    chk("preempt_first_state", fs, 2);
    chk("preempt_len", nb, 45);

    // simultaneous rises, then fire rise during GAP
    do_reset();
    fire = 1'b1; hit = 1'b1;
    run_seq(1, 22, nb, n2, n3, n4, fh, fs, nh);
    chk("simul_first_state", fs, 2);
    chk("gapfire_len", nb, 45);
    chk("gapfire_gap_len", n3, 5);

    // muted hit sequence
    do_reset();
    en = 1'b0; hit = 1'b1;
    run_seq(-1, -1, nb, n2, n3, n4, fh, fs, nh);
    chk("mute_len", nb, 45);
    chk("mute_hit2_len", n4, 20);
    chk("mute_piezo_highs", nh, 0);
    en = 1'b1;

    // reset in the middle of HIT2
    do_reset();
    hit = 1'b1;
    for (int i = 0; i < 28; i++) step();
    chk("midhit2_state", int'(state_o), 4);
    rst = 1'b1;
    step();
    chk("midhit2_reset_state", int'(state_o), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("after_reset_idle", int'(state_o), 0);
    end

    // random stimulus against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) fire = ~fire;
      if ($urandom_range(0, 29) == 0) hit = ~hit;
      if ($urandom_range(0, 19) == 0) en = ~en;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piezo_sound_ctrl.md
# piezo_sound_ctrl

Downstream effects stage for the tank game. Consumes the `fire` and `hit` signals from the tank/shell state memories and drives the piezo buzzer with a square-wave sound sequence:
- a single short tone when a shell is fired;
- a two-note descending tone with a silent gap when a shell hits.

Pure sequential block: an edge-detect, priority FSM, duration counter and half-period tone divider.

## Interface
Parameters:
- `CNT_W`, 24, width of the duration and tone counters.
- `FIRE_HALF`, 12000, fire-tone half-period in clk cycles.
- `HIT1_HALF`, 9556, first hit-note half-period in clk cycles.
- `HIT2_HALF`, 19112, second hit-note half-period in clk cycles.
- `NOTE_LEN`, 5000000, cycles spent in each tone state.
- `GAP_LEN`, 1250000, cycles of silence between the two hit notes.

Ports:
- `clk` in 1: system clock. One clock; all state is in this domain.
- `rst` in 1: reset, synchronous, active-high.
- `fire` in 1: level from the tank state memory; a rising edge starts the fire sound.
- `hit` in 1: level from the shell state memory; a rising edge starts the hit sound.
- `en` in 1: sound enable. When 0, `piezo` is muted; the FSM keeps running.
- `piezo` out 1: square-wave drive to the buzzer.
- `busy` out 1: high while the FSM is not in IDLE.
- `state_o` out 3: current state encoding, for debug.

## Operation
- Edge detect:
  - Registers `fire_d` and `hit_d`.
  - `fire_rise = fire & ~fire_d`; `hit_rise = hit & ~hit_d`.
  - While `rst` is high, `fire_d`/`hit_d` load the current inputs, so a level that is already high at reset release is not a rise.
- States and encodings: IDLE=0, FIRE=1, HIT1=2, GAP=3, HIT2=4.
- Transitions, evaluated every cycle in this priority order:
  1. `hit_rise` in any state → HIT1. This restarts the hit sequence and preempts FIRE.
  2. `fire_rise` in IDLE or FIRE → FIRE, restarting it. `fire_rise` in HIT1, GAP or HIT2 is ignored.
  3. On duration expiry:
     - FIRE → IDLE
     - HIT1 → GAP
     - GAP → HIT2
     - HIT2 → IDLE
- Duration counter:
  - Cleared on every state entry, including re-entry of the same state.
  - Increments each cycle.
  - Expires when it reaches LEN−1, where LEN is NOTE_LEN for tone states and GAP_LEN for GAP.
- Tone divider:
  - Half counter and a `tone` register, both cleared to 0 on every state entry.
  - In a tone state, the half counter counts 0..HALF−1. At HALF−1 it wraps to 0 and `tone` toggles.
  - HALF is the parameter for the current state.
- Output: `piezo = tone & en & (state ∈ {FIRE, HIT1, HIT2})`, registered. `piezo` is 0 in IDLE and GAP.
- Width rules: every HALF and LEN parameter must be ≥ 2 and ≤ 2^CNT_W − 1. Counters never exceed LEN−1.

## Timing
- Reset values:
  - `piezo` = 0
  - `busy` = 0
  - `state_o` = 0 (IDLE)
  - all counters and `tone` = 0
- Reset mid-sequence aborts the sequence immediately on the next edge. No sound resumes after release unless a new rise occurs.
- Start latency: a rise sampled at edge k puts the FSM in the target state after edge k. `busy` and `state_o` reflect this in cycle k+1.
- First high on `piezo` appears HALF+1 cycles after the state entry edge (toggle, plus the output register).
- Each tone state lasts exactly NOTE_LEN cycles; GAP lasts exactly GAP_LEN cycles.
- Full hit sequence: 2·NOTE_LEN + GAP_LEN cycles from entry to IDLE.
- Simultaneous `fire_rise` and `hit_rise` in the same cycle: HIT1 wins.
- A rise coinciding with the expiry cycle: the rise rule wins, and the counter restarts.
- Toggling `en` mid-tone gates `piezo` with 1-cycle latency. Tone phase and durations are unaffected.

## Test plan
Bench parameters: FIRE_HALF=3, HIT1_HALF=2, HIT2_HALF=4, NOTE_LEN=20, GAP_LEN=5, `en`=1 unless stated.
- Reset with `fire`=1 held through release → `state_o` stays 0 and `piezo` stays 0 for 30 cycles.
- `fire` 0→1 → `busy`=1 for 20 cycles. `piezo` is a period-6 square wave, first high 4 cycles after entry. `busy` returns to 0 after that.
- `hit` 0→1 → `state_o` sequence is 2 for 20 cycles, 3 for 5, 4 for 20, then 0.
  - `piezo` has period 4 in HIT1, is 0 in GAP, and has period 8 in HIT2.
- `fire` rise, then `hit` rise 7 cycles later → FIRE is aborted, HIT1 is entered on that edge, and the full 45-cycle hit sequence follows.
- `fire` and `hit` rise in the same cycle → `state_o`=2. `fire` rise during GAP → ignored, and the sequence length is still 45 cycles.
- `en`=0 during a hit sequence → `piezo` stays 0 throughout, `busy`/`state_o` timing is identical to the unmuted case, and `rst` asserted mid-HIT2 gives `state_o`=0 after the next edge.
